regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port among NUM_REQ requesters using a valid/ready handshake and round-robin priority.
- Registers the winning request and drives one write per cycle into the register file write port: enable, address and data.
- The register file's internal address decoder tree consumes wr_addr and wr_en directly.
- Sits between execution/load units and the register file.

Parameters:
NUM_REQ, 4, number of requesters; power of 2, 2..8
ADDR_W, 5, register address width (32 registers)
DATA_W, 64, register data width
ID_W, $clog2(NUM_REQ), width of the grant index

Ports:
clk  input  1  clock; all state changes on posedge
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  per-requester write request
req_addr  input  NUM_REQ x ADDR_W  per-requester destination register
req_data  input  NUM_REQ x DATA_W  per-requester write data
req_ready  output  NUM_REQ  one-hot (or zero) accept strobe, combinational
hold  input  1  freezes arbitration (e.g. register file read-modify test mode)
wr_en  output  1  write enable to register file
wr_addr  output  ADDR_W  write address to register file
wr_data  output  DATA_W  write data to register file
wr_id  output  ID_W  index of requester whose write is on wr_*

Behaviour:
- Reset (async, active-high): wr_en=0, wr_addr=0, wr_data=0, wr_id=0, last-grant pointer=NUM_REQ-1. After reset, requester 0 has highest priority.
- Transfer: requester i transfers in a cycle when req_valid[i] && req_ready[i] at posedge clk.
- Requester obligations: it holds req_addr and req_data stable while req_valid is high and unaccepted. It may not retract req_valid before acceptance; the bench checks this.
- Arbitration (combinational, same cycle):
  - Search order is ptr+1, ptr+2, ... wrapping modulo NUM_REQ; ptr itself is last.
  - The first requester with valid=1 gets req_ready=1.
  - At most one bit of req_ready is set.
  - req_ready is all zero when hold=1 or no valid.
- Pointer update: on a transfer, ptr <= granted index. Otherwise ptr is unchanged, including while hold=1.
- Output stage (registered, latency 1):
  - Transfer in cycle N: cycle N+1 carries wr_en=1, with wr_addr/wr_data/wr_id = the granted request.
  - No transfer in cycle N: cycle N+1 has wr_en=0, and wr_addr/wr_data/wr_id hold their previous values.
  - Back-to-back transfers give wr_en=1 on consecutive cycles. Throughput is 1 write/cycle; there is no backpressure from the register file.
- Fairness: with all NUM_REQ valid continuously, grants cycle i, i+1, ... and each requester is granted exactly once per NUM_REQ cycles.
- hold:
  - When asserted, it blocks new grants in the same cycle.
  - A write already registered still completes (wr_en=1 the next cycle).
  - On deassertion, arbitration resumes from the unchanged ptr.
- Wrap-around: after ptr=NUM_REQ-1, the search starts at 0.
- Simultaneous events: a single valid requester equal to ptr is still granted. The wrapped search reaches it last, but it is the only candidate.
- Reset mid-operation: a pending registered write is discarded (wr_en forced 0 immediately, asynchronously). Requesters must re-present.
- Writes to address 0..2^ADDR_W-1 are all passed through; zero-register policy belongs to the register file.

Decomposition:
- Shared package regfile_pkg holds:
  - constants REG_ADDR_W=5, REG_DATA_W=64, NUM_WR_REQ=4;
  - a typedef wr_req_t {addr, data};
  - a typedef wr_port_t {en, addr, data}.
- One sub-module: rr_pick, a purely combinational round-robin picker.
  - Inputs: valid[NUM_REQ], ptr[ID_W], allow.
  - Outputs: grant onehot[NUM_REQ], grant_idx[ID_W], any.
  - The top level holds ptr, the output register, and the req_ready/mux logic.

Test Plan:
1. Reset, then single request: assert reset mid-stream, release, drive req_valid=4'b0100 with addr=7, data=64'hDEAD_BEEF. Expect req_ready=4'b0100 the same cycle; next cycle wr_en=1, wr_addr=7, wr_data=DEAD_BEEF, wr_id=2; the cycle after, wr_en=0.
2. Fairness: hold req_valid=4'b1111 for 8 cycles after reset. Expect grant order 0,1,2,3,0,1,2,3, wr_en=1 for 8 consecutive cycles, and wr_id matching that order with latency 1.
3. Pointer skip: after requester 1 is granted, drive req_valid=4'b0011. Expect requester 0 granted, not 1; with 4'b0010 alone next, requester 1 is granted.
4. hold: with req_valid=4'b1000, assert hold for 3 cycles. Expect req_ready=0 and wr_en=0 throughout; deassert hold and expect requester 3 granted the same cycle.
5. Async reset during a pending write: grant a request, then assert reset before the next posedge. Expect wr_en=0 immediately without a clock edge; after release, requester 0 has highest priority.
6. Stable-data check: stall requester 2 behind requesters 0 and 1, with all of 0, 1, 2 valid. Requester 2's data is written in the third write cycle with unchanged value, and req_ready is never multi-hot in any cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and write-port types for the register file
//               and its write-side arbitration logic.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 64;
   localparam int NUM_WR_REQ = 4;

   // One pending write as presented by a requester.
   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wr_req_t;

   // The register file's write port.
   typedef struct packed {
      logic                  en;
      logic [REG_ADDR_W-1:0] addr;
      logic [REG_DATA_W-1:0] data;
   } wr_port_t;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Searches ptr+1, ptr+2, ...
//               wrapping, with ptr itself considered last, and returns the
//               first valid requester as a one-hot grant plus its index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid_i,
   input  logic [ID_W-1:0]    ptr_i,
   input  logic               allow_i,
   output logic [NUM_REQ-1:0] grant_onehot_o,
   output logic [ID_W-1:0]    grant_idx_o,
   output logic               any_o
);

   logic            found;
   logic [ID_W-1:0] cand;

   // Walk the wrapped search order; NUM_REQ is a power of two so the index
   // sum wraps naturally by truncation, and k == NUM_REQ lands on ptr itself.
   always_comb begin
      grant_onehot_o = '0;
      grant_idx_o    = '0;
      found          = 1'b0;
      cand           = '0;
      if (allow_i) begin
         for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ptr_i + ID_W'(k);
            if (!found && valid_i[cand]) begin
               found                = 1'b1;
               grant_idx_o          = cand;
               grant_onehot_o[cand] = 1'b1;
            end
         end
      end
      any_o = found;
   end

endmodule : rr_pick
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register file's single write port among NUM_REQ
//               requesters. Round-robin grant via valid/ready, one registered
//               write per cycle (latency 1) onto wr_en/wr_addr/wr_data/wr_id.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter
   import regfile_pkg::*;
#(
   parameter int NUM_REQ = NUM_WR_REQ,
   parameter int ADDR_W  = REG_ADDR_W,
   parameter int DATA_W  = REG_DATA_W,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic                           hold,
   output logic                           wr_en,
   output logic [ADDR_W-1:0]              wr_addr,
   output logic [DATA_W-1:0]              wr_data,
   output logic [ID_W-1:0]                wr_id
);

   // Pointer reset value makes requester 0 the first one searched.
   localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

   logic [ID_W-1:0]    ptr_q,     ptr_d;
   logic               wr_en_q,   wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]  wr_data_q, wr_data_d;
   logic [ID_W-1:0]    wr_id_q,   wr_id_d;

   logic [NUM_REQ-1:0] grant_onehot;
   logic [ID_W-1:0]    grant_idx;
   logic               grant_any;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr_pick (
      .valid_i        (req_valid),
      .ptr_i          (ptr_q),
      .allow_i        (!hold),
      .grant_onehot_o (grant_onehot),
      .grant_idx_o    (grant_idx),
      .any_o          (grant_any)
   );

   // The grant is only ever raised on a valid line, so ready doubles as the
   // transfer strobe and any grant is a completed handshake.
   assign req_ready = grant_onehot;

   // Next state: capture the winning request and advance the pointer on a
   // transfer; otherwise keep address/data/id and pointer, drop the enable.
   always_comb begin
      ptr_d     = ptr_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_id_d   = wr_id_q;
      if (grant_any) begin
         ptr_d     = grant_idx;
         wr_en_d   = 1'b1;
         wr_addr_d = req_addr[grant_idx];
         wr_data_d = req_data[grant_idx];
         wr_id_d   = grant_idx;
      end
   end

   // State and output register; reset discards any pending write at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_q     <= PTR_RST;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wr_id_q   <= '0;
      end else begin
         ptr_q     <= ptr_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wr_id_q   <= wr_id_d;
      end
   end

   assign wr_en   = wr_en_q;
   assign wr_addr = wr_addr_q;
   assign wr_data = wr_data_q;
   assign wr_id   = wr_id_q;

endmodule : regfile_write_arbiter
`default_nettype wire

// File: tb/tb_regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_arbiter
// Description : Directed, table-driven bench for regfile_write_arbiter plus
//               hand-written sequences for reset and stall corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_write_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ADDR_W  = 5;
   localparam int DATA_W  = 64;
   localparam int ID_W    = 2;

   logic                           clk;
   logic                           reset;
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]             req_ready;
   logic                           hold;
   logic                           wr_en;
   logic [ADDR_W-1:0]              wr_addr;
   logic [DATA_W-1:0]              wr_data;
   logic [ID_W-1:0]                wr_id;

   int n_chk  = 0;
   int n_fail = 0;

   regfile_write_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .ID_W    (ID_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .hold      (hold),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .wr_id     (wr_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic               hold;
      logic [NUM_REQ-1:0] valid;
      logic [NUM_REQ-1:0] exp_ready;
      logic               exp_en;
      logic [ID_W-1:0]    exp_id;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic h, input logic [3:0] v, input logic [3:0] r,
                      input logic e, input logic [1:0] id);
      vec_t x;
      x.hold = h; x.valid = v; x.exp_ready = r; x.exp_en = e; x.exp_id = id;
      vecs.push_back(x);
   endtask

   task automatic do_reset();
      @(negedge clk);
      req_valid = '0;
      hold      = 1'b0;
      reset     = 1'b1;
      #2;
      reset     = 1'b0;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   logic [NUM_REQ-1:0] pending;
   logic [DATA_W-1:0]  t6_data [NUM_REQ];

   initial begin
      reset     = 1'b1;
      hold      = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      #1;
      // Reset state
      chk("rst wr_en",   64'(wr_en),   64'd0);
      chk("rst wr_addr", 64'(wr_addr), 64'd0);
      chk("rst wr_data", wr_data,      64'd0);
      chk("rst wr_id",   64'(wr_id),   64'd0);
      chk("rst ready",   64'(req_ready), 64'd0);
      #20;
      @(negedge clk);
      reset = 1'b0;

      // ---------------- Test 1: reset mid-stream then single request -------
      @(negedge clk);
      req_valid = 4'b1111;
      @(posedge clk); #1;
      do_reset();
      @(negedge clk);
      req_addr[2] = 5'd7;
      req_data[2] = 64'hDEAD_BEEF;
      req_valid   = 4'b0100;
      #1;
      chk("t1 ready", 64'(req_ready), 64'h4);
      @(posedge clk); #1;
      chk("t1 wr_en",   64'(wr_en),   64'd1);
      chk("t1 wr_addr", 64'(wr_addr), 64'd7);
      chk("t1 wr_data", wr_data,      64'hDEAD_BEEF);
      chk("t1 wr_id",   64'(wr_id),   64'd2);
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      chk("t1 idle ready", 64'(req_ready), 64'd0);
      @(posedge clk); #1;
      chk("t1 wr_en low",  64'(wr_en),   64'd0);
      chk("t1 addr hold",  64'(wr_addr), 64'd7);

      // ---------------- Table: fairness, pointer skip, hold, wrap ----------
      do_reset();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_addr[i] = 5'(10 + i);
         req_data[i] = 64'h1000 + 64'(i);
      end
      for (int r = 0; r < 2; r++) begin
         add(0, 4'b1111, 4'b0001, 1, 2'd0);
         add(0, 4'b1111, 4'b0010, 1, 2'd1);
         add(0, 4'b1111, 4'b0100, 1, 2'd2);
         add(0, 4'b1111, 4'b1000, 1, 2'd3);
      end
      add(0, 4'b0010, 4'b0010, 1, 2'd1);  // ptr -> 1
      add(0, 4'b0011, 4'b0001, 1, 2'd0);  // 0 beats 1 after 1 was served
      add(0, 4'b0010, 4'b0010, 1, 2'd1);
      add(1, 4'b1000, 4'b0000, 0, 2'd1);  // hold blocks grant, outputs hold
      add(1, 4'b1000, 4'b0000, 0, 2'd1);
      add(1, 4'b1000, 4'b0000, 0, 2'd1);
      add(0, 4'b1000, 4'b1000, 1, 2'd3);  // released: granted same cycle
      add(0, 4'b0000, 4'b0000, 0, 2'd3);
      add(0, 4'b1000, 4'b1000, 1, 2'd3);  // only candidate equals ptr
      add(0, 4'b1001, 4'b0001, 1, 2'd0);  // wrap: 0 searched first after 3

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         hold      = vecs[i].hold;
         req_valid = vecs[i].valid;
         #1;
         chk($sformatf("vec%0d ready", i), 64'(req_ready), 64'(vecs[i].exp_ready));
         @(posedge clk); #1;
         chk($sformatf("vec%0d wr_en", i), 64'(wr_en), 64'(vecs[i].exp_en));
         chk($sformatf("vec%0d wr_id", i), 64'(wr_id), 64'(vecs[i].exp_id));
         chk($sformatf("vec%0d wr_addr", i), 64'(wr_addr), 64'(10 + vecs[i].exp_id));
         chk($sformatf("vec%0d wr_data", i), wr_data, 64'h1000 + 64'(vecs[i].exp_id));
      end

      // ---------------- Test 5: async reset during pending write -----------
      do_reset();
      @(negedge clk);
      req_valid = 4'b0010;
      #1;
      chk("t5 ready", 64'(req_ready), 64'h2);
      @(posedge clk); #1;
      chk("t5 wr_en pending", 64'(wr_en), 64'd1);
      req_valid = 4'b0000;
      #1;
      reset = 1'b1;
      #1;
      chk("t5 async wr_en",   64'(wr_en),   64'd0);
      chk("t5 async wr_addr", 64'(wr_addr), 64'd0);
      chk("t5 async wr_data", wr_data,      64'd0);
      chk("t5 async wr_id",   64'(wr_id),   64'd0);
      #1;
      reset = 1'b0;
      @(negedge clk);
      req_valid = 4'b1111;
      #1;
      chk("t5 prio after rst", 64'(req_ready), 64'h1);
      @(posedge clk); #1;
      chk("t5 wr_id", 64'(wr_id), 64'd0);

      // ---------------- Test 6: stalled requester keeps its data -----------
      do_reset();
      t6_data[0] = 64'h0101_0101_0101_0101;
      t6_data[1] = 64'h0202_0202_0202_0202;
      t6_data[2] = 64'hCAFE_F00D_1234_5678;
      t6_data[3] = 64'h0;
      for (int i = 0; i < NUM_REQ; i++) req_data[i] = t6_data[i];
      pending = 4'b0111;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         req_valid = pending;   // requesters hold valid until accepted
         #1;
         chk($sformatf("t6 onehot c%0d", k), 64'($countones(req_ready) <= 1), 64'd1);
         chk($sformatf("t6 ready c%0d", k), 64'(req_ready), 64'(4'b0001 << k));
         @(posedge clk);
         pending = pending & ~req_ready;
         #1;
         chk($sformatf("t6 wr_en c%0d", k), 64'(wr_en), 64'd1);
         chk($sformatf("t6 wr_id c%0d", k), 64'(wr_id), 64'(k));
         chk($sformatf("t6 wr_data c%0d", k), wr_data, t6_data[k]);
      end
      chk("t6 all served", 64'(pending), 64'd0);
      @(negedge clk);
      req_valid = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_regfile_write_arbiter
`default_nettype wire
